// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide sequencer: op classes, writeback select codes, FSM states.
package hilo_div_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        SH_SLL   = 3'b011,
        DIV_MFHI = 3'b100,
        DIV_MFLO = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } op_class_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_HI  = 2'b01,
        WB_LO  = 2'b10,
        WB_SHF = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    function automatic logic [1:0] wb_map(input logic [2:0] cls);
        logic [1:0] sel;
        sel = WB_ALU;
        case (cls)
            DIV_MFHI: sel = WB_HI;
            DIV_MFLO: sel = WB_LO;
            SH_SLL:   sel = WB_SHF;
            default:  sel = WB_ALU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_iter_counter.sv
// Iteration counter for the shift-subtract divider; flags the final iteration.
module div_iter_counter #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CNT_W'(DIV_CYCLES - 1));

endmodule

// File: rtl/hilo_div_ctrl.sv
// Divide sequencer: drives load/step/commit strobes, stalls HI/LO hazards, registers the writeback select.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    input  logic [2:0] op_class,
    input  logic       div_req,
    input  logic       divisor_zero,
    input  logic       abort,
    output logic       div_load,
    output logic       div_step,
    output logic       hilo_we,
    output logic       div_by_zero,
    output logic       busy,
    output logic       stall,
    output logic [1:0] wb_sel,
    output logic       wb_sel_valid
);

    div_state_e state, state_nxt;
    logic       dz, dz_nxt;
    logic       cnt_tc;

    // Counter only runs in RUN; any other state (LOAD in particular) or an abort clears it.
    div_iter_counter #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  ((state != S_RUN) | abort),
        .en   (state == S_RUN),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            dz    <= 1'b0;
        end else begin
            state <= state_nxt;
            dz    <= dz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dz_nxt    = dz;
        case (state)
            S_IDLE: if (op_valid && div_req && !abort) state_nxt = S_LOAD;
            S_LOAD: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (divisor_zero) begin
                    state_nxt = S_DONE;
                    dz_nxt    = 1'b1;
                end else
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (cnt_tc)
                    state_nxt = S_DONE;
            end
            // Commit cannot be cancelled once reached.
            S_DONE: begin
                state_nxt = S_IDLE;
                dz_nxt    = 1'b0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign div_load    = (state == S_LOAD);
    assign div_step    = (state == S_RUN);
    assign hilo_we     = (state == S_DONE);
    assign div_by_zero = (state == S_DONE) & dz;
    assign busy        = (state != S_IDLE);

    // HI/LO readers and a second DIVU wait for the unit; includes the DONE cycle so mfhi/mflo see committed values.
    assign stall = op_valid & busy &
                   (div_req | (op_class == DIV_MFHI) | (op_class == DIV_MFLO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_sel       <= WB_ALU;
            wb_sel_valid <= 1'b0;
        end else if (op_valid && !stall) begin
            wb_sel       <= wb_map(op_class);
            wb_sel_valid <= 1'b1;
        end else begin
            wb_sel       <= WB_ALU;
            wb_sel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: latency, zero divisor, hazard stall, abort, reset and wb_sel mapping.
module tb_hilo_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid, div_req, divisor_zero, abort;
    logic [2:0] op_class;
    logic       div_load, div_step, hilo_we, div_by_zero, busy, stall, wb_sel_valid;
    logic [1:0] wb_sel;

    int vec = 0;
    int bad = 0;

    hilo_div_ctrl #(.DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_class    (op_class),
        .div_req     (div_req),
        .divisor_zero(divisor_zero),
        .abort       (abort),
        .div_load    (div_load),
        .div_step    (div_step),
        .hilo_we     (hilo_we),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .stall       (stall),
        .wb_sel      (wb_sel),
        .wb_sel_valid(wb_sel_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        op_valid     = 1'b0;
        div_req      = 1'b0;
        divisor_zero = 1'b0;
        abort        = 1'b0;
        op_class     = 3'b000;
    endtask

    task automatic issue_div();
        op_valid = 1'b1;
        div_req  = 1'b1;
        op_class = 3'b010;
    endtask

    int steps, we_cnt, stl, wbv, bsy;

    initial begin
        rst_n = 1'b0;
        idle_in();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_load", div_load, 0);
        chk("rst_step", div_step, 0);
        chk("rst_we", hilo_we, 0);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_wbsel", wb_sel, 0);
        chk("rst_wbv", wb_sel_valid, 0);
        rst_n = 1'b1;
        cyc();

        // add, sll, mfhi back to back while idle
        op_valid = 1'b1; op_class = 3'b010; #1;
        chk("t6_stall_add", stall, 0);
        cyc();
        chk("t6_wb_add", wb_sel, 2'b00);
        chk("t6_wbv_add", wb_sel_valid, 1);
        op_class = 3'b011; #1;
        chk("t6_stall_sll", stall, 0);
        cyc();
        chk("t6_wb_sll", wb_sel, 2'b11);
        op_class = 3'b100; #1;
        chk("t6_stall_mfhi", stall, 0);
        cyc();
        chk("t6_wb_mfhi", wb_sel, 2'b01);
        chk("t6_wbv_mfhi", wb_sel_valid, 1);
        idle_in();
        cyc();
        chk("t6_bubble", wb_sel_valid, 0);

        // normal 32-step divide
        issue_div(); #1;
        chk("t2_stall_T", stall, 0);
        cyc();
        idle_in();
        chk("t2_load", div_load, 1);
        chk("t2_busy", busy, 1);
        chk("t2_nostep", div_step, 0);
        chk("t2_wbv", wb_sel_valid, 1);
        steps = 0; we_cnt = 0;
        repeat (32) begin
            cyc();
            steps += int'(div_step);
            we_cnt += int'(hilo_we);
        end
        chk("t2_steps", steps, 32);
        chk("t2_early_we", we_cnt, 0);
        cyc();
        chk("t2_we_T34", hilo_we, 1);
        chk("t2_step_T34", div_step, 0);
        chk("t2_dz_T34", div_by_zero, 0);
        cyc();
        chk("t2_busy_T35", busy, 0);
        chk("t2_we_T35", hilo_we, 0);

        // zero divisor
        issue_div();
        cyc();
        idle_in();
        divisor_zero = 1'b1;
        chk("t3_load", div_load, 1);
        cyc();
        divisor_zero = 1'b0;
        chk("t3_we", hilo_we, 1);
        chk("t3_dz", div_by_zero, 1);
        chk("t3_nostep", div_step, 0);
        cyc();
        chk("t3_busy", busy, 0);
        chk("t3_dz_clr", div_by_zero, 0);

        // mflo at T+5 held until T+35
        issue_div();
        cyc();
        idle_in();
        repeat (4) cyc();
        op_valid = 1'b1; op_class = 3'b101;
        stl = 0; wbv = 0; we_cnt = 0;
        repeat (30) begin
            #1;
            stl += int'(stall);
            we_cnt += int'(hilo_we);
            cyc();
            wbv += int'(wb_sel_valid);
        end
        chk("t4_stall_cnt", stl, 30);
        chk("t4_bubbles", wbv, 0);
        chk("t4_we_cnt", we_cnt, 1);
        #1;
        chk("t4_stall_T35", stall, 0);
        cyc();
        chk("t4_wb_mflo", wb_sel, 2'b10);
        chk("t4_wbv_mflo", wb_sel_valid, 1);
        idle_in();

        // abort at RUN iteration 10, then immediate new DIVU
        issue_div();
        cyc();
        idle_in();
        repeat (10) cyc();
        chk("t5_step_it10", div_step, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t5_idle", busy, 0);
        chk("t5_no_we", hilo_we, 0);
        issue_div();
        cyc();
        idle_in();
        chk("t5_reload", div_load, 1);

        // reset mid-RUN
        repeat (5) cyc();
        chk("t1_running", div_step, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_step", div_step, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        we_cnt = 0; bsy = 0;
        repeat (40) begin
            cyc();
            we_cnt += int'(hilo_we);
            bsy += int'(busy);
        end
        chk("t1_never_we", we_cnt, 0);
        chk("t1_stay_idle", bsy, 0);

        // abort beats div_req in IDLE
        issue_div();
        abort = 1'b1;
        cyc();
        idle_in();
        chk("abort_wins", busy, 0);
        cyc();
        chk("abort_no_load", div_load, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
